// File: rtl/uart_bram_loader.sv
// uart_bram_loader
//   Receives 8N1 UART bytes, packs them little-endian into BRAM_WIDTH-bit
//   words and issues one BRAM write per word at addresses 0..BRAM_DEPTH-1.
//   Ports:
//     clk_in    - system clock
//     rst_in    - asynchronous reset, active-low
//     uart_rxd  - serial line, idle high, asynchronous to clk_in
//     start_in  - single-cycle pulse, arms (or restarts) a load at address 0
//     addr_out  - BRAM write address
//     data_out  - BRAM write data
//     wea_out   - single-cycle write strobe
//     busy_out  - high while a load is armed
//     done_out  - single-cycle pulse after the final write
//     error_out - sticky framing-error flag, cleared by start_in
module uart_bram_loader #(
  parameter int BRAM_WIDTH = 8,
  parameter int BRAM_DEPTH = 320*240,
  parameter int BAUD_RATE  = 3000000,
  parameter int CLK_FREQ   = 100000000
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          uart_rxd,
  input  logic                          start_in,
  output logic [$clog2(BRAM_DEPTH)-1:0] addr_out,
  output logic [BRAM_WIDTH-1:0]         data_out,
  output logic                          wea_out,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          error_out
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int BPW        = (BRAM_WIDTH + 7) / 8;
  localparam int WORD_W     = BPW * 8;
  localparam int IDX_W      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CNT_W      = $clog2(BIT_CYCLES + 1);
  localparam int ADDR_W     = $clog2(BRAM_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {L_IDLE, L_LOADING} ld_state_t;

  logic             r_rxd_meta;
  logic             r_rxd_sync;
  logic             r_rxd_prev;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_byte;
  logic             r_byte_valid;
  logic             r_frame_err;

  ld_state_t        r_ld_state;
  logic [IDX_W-1:0] r_byte_idx;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_next;
  logic             w_word_done;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection;
  // all flops idle high so reset release never looks like a start bit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  // Receive FSM: mid-bit sampling of start, 8 data bits (LSB first) and stop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= 3'd0;
      r_rx_shift   <= 8'd0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rxd_prev && !r_rxd_sync) begin
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == CNT_W'(HALF - 1)) begin
            r_rx_cnt <= '0;
            r_rx_bit <= 3'd0;
            // Still low at mid-bit: a real start bit, otherwise a glitch.
            r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == CNT_W'(BIT_CYCLES - 1)) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == CNT_W'(BIT_CYCLES - 1)) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rxd_sync) begin
              r_byte       <= r_rx_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Word assembly: the incoming byte lands in the slot selected by the byte
  // index, so the first byte of a word ends up in bits [7:0].
  always_comb begin
    w_word_next = r_word;
    w_word_next[r_byte_idx*8 +: 8] = r_byte;
    w_word_done = (r_byte_idx == IDX_W'(BPW - 1));
  end

  // Loader FSM: start_in has priority over everything, including a write
  // that would otherwise be issued in the same cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_ld_state <= L_IDLE;
      r_byte_idx <= '0;
      r_word     <= '0;
      addr_out   <= '0;
      data_out   <= '0;
      wea_out    <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      wea_out  <= 1'b0;
      done_out <= 1'b0;
      if (start_in) begin
        r_ld_state <= L_LOADING;
        r_byte_idx <= '0;
        r_word     <= '0;
        addr_out   <= '0;
        busy_out   <= 1'b1;
        error_out  <= 1'b0;
      end else begin
        if (r_frame_err) begin
          error_out <= 1'b1;
        end
        case (r_ld_state)
          L_IDLE: begin
            // busy stays high through the done_out cycle, drops here after.
            busy_out <= 1'b0;
          end
          L_LOADING: begin
            // Address advances on the edge that ends the strobe cycle.
            if (wea_out) begin
              if (addr_out == ADDR_W'(BRAM_DEPTH - 1)) begin
                done_out   <= 1'b1;
                r_ld_state <= L_IDLE;
              end else begin
                addr_out <= addr_out + ADDR_W'(1);
              end
            end
            if (r_byte_valid) begin
              r_word <= w_word_next;
              if (w_word_done) begin
                data_out   <= w_word_next[BRAM_WIDTH-1:0];
                wea_out    <= 1'b1;
                r_byte_idx <= '0;
              end else begin
                r_byte_idx <= r_byte_idx + IDX_W'(1);
              end
            end
          end
          default: r_ld_state <= L_IDLE;
        endcase
      end
    end
  end

endmodule
